// File: rtl/seq_generator.sv
// Parameterised sequence generator: one-hot ring, Johnson, binary and Gray codes
// stepped forward or backward through one period, with a wrap pulse at each period boundary.
module seq_generator #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [NBITS-1:0] seq_out,
    output logic [NBITS-1:0] pos,
    output logic             wrap,
    output logic             valid
);

    // The index is one bit wider than the output so that 2^NBITS can be formed as a period.
    localparam int IW = NBITS + 1;

    localparam logic [1:0] MODE_RING = 2'b00;
    localparam logic [1:0] MODE_JOHN = 2'b01;
    localparam logic [1:0] MODE_BIN  = 2'b10;

    logic [NBITS-1:0] seq_q, seq_d;
    logic [NBITS-1:0] pos_q;
    logic [IW-1:0]    pos_d;
    logic [1:0]       lmode_q;
    logic             wrap_q, wrap_d;
    logic             valid_q;
    logic [IW-1:0]    period;
    logic [IW-1:0]    idx;

    function automatic logic [IW-1:0] period_of(input logic [1:0] m);
        logic [IW-1:0] p;
        case (m)
            MODE_RING: p = IW'(NBITS);
            MODE_JOHN: p = IW'(2 * NBITS);
            default:   p = IW'(1) << NBITS;
        endcase
        return p;
    endfunction

    function automatic logic [NBITS-1:0] seq_of(input logic [1:0] m, input logic [IW-1:0] k);
        logic [NBITS-1:0] s;
        logic [NBITS-1:0] ones;
        ones = '1;
        case (m)
            MODE_RING: s = NBITS'(1) << k;
            MODE_JOHN: begin
                if (k < IW'(NBITS)) s = (NBITS'(1) << k) - NBITS'(1);
                else                s = ones << (k - IW'(NBITS));
            end
            MODE_BIN:  s = k[NBITS-1:0];
            default:   s = k[NBITS-1:0] ^ (k[NBITS-1:0] >> 1);
        endcase
        return s;
    endfunction

    always_comb begin
        period = period_of(lmode_q);
        idx    = {1'b0, pos_q};
        pos_d  = idx;
        wrap_d = 1'b0;
        if (!dir) begin
            wrap_d = (idx == period - IW'(1));
            pos_d  = wrap_d ? '0 : idx + IW'(1);
        end else begin
            wrap_d = (idx == '0);
            pos_d  = wrap_d ? period - IW'(1) : idx - IW'(1);
        end
        seq_d = seq_of(lmode_q, pos_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q   <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            lmode_q <= 2'b00;
        end else if (start) begin
            pos_q   <= '0;
            lmode_q <= mode;
            valid_q <= 1'b1;
            wrap_q  <= 1'b0;
            seq_q   <= (mode == MODE_RING) ? NBITS'(1) : '0;
        end else if (valid_q && enable) begin
            pos_q  <= pos_d[NBITS-1:0];
            seq_q  <= seq_d;
            wrap_q <= wrap_d;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign seq_out = seq_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;
    assign valid   = valid_q;

endmodule
